// File: rtl/fp_arith_pkg.sv
// Shared Q16.16 fixed-point definitions and the round/saturate helper used by
// matrix_mult, matrix_add and the matrix-vector multiplier.
package fp_arith_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int FRAC_BITS  = 16;
  // Widest accumulator fp_round_sat accepts; covers inner dimensions up to 128.
  localparam int ACC_MAX_W  = 2 * DATA_WIDTH + 8;

  localparam logic signed [DATA_WIDTH-1:0] FP_ZERO = 32'sh0000_0000;
  localparam logic signed [DATA_WIDTH-1:0] FP_MAX  = 32'sh7FFF_FFFF;
  localparam logic signed [DATA_WIDTH-1:0] FP_MIN  = 32'sh8000_0000;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] value;
    logic                         ovf;
  } fp_rs_t;

  // Round half-up (ties toward +inf), drop FRAC_BITS, clamp into DATA_WIDTH.
  // The caller sign-extends its accumulator to ACC_MAX_W bits.
  function automatic fp_rs_t fp_round_sat(input logic signed [ACC_MAX_W-1:0] acc);
    logic signed [ACC_MAX_W:0] sum;
    logic signed [ACC_MAX_W:0] shr;
    logic signed [ACC_MAX_W:0] max_ext;
    logic signed [ACC_MAX_W:0] min_ext;
    fp_rs_t res;
    // One guard bit keeps the rounding add from wrapping.
    sum     = $signed({acc[ACC_MAX_W-1], acc})
            + $signed({{(ACC_MAX_W + 1 - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}});
    shr     = sum >>> FRAC_BITS;
    max_ext = $signed({{(ACC_MAX_W + 1 - DATA_WIDTH){1'b0}}, FP_MAX});
    min_ext = $signed({{(ACC_MAX_W + 1 - DATA_WIDTH){1'b1}}, FP_MIN});
    res.ovf   = 1'b0;
    res.value = shr[DATA_WIDTH-1:0];
    if (shr > max_ext) begin
      res.value = FP_MAX;
      res.ovf   = 1'b1;
    end else if (shr < min_ext) begin
      res.value = FP_MIN;
      res.ovf   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/matrix_mult_if.sv
// Bus bundle for matrix_mult. Optional trans_b exists only when
// MATRIX_MULT_TRANSPOSE_B_EN is defined.
//
// Handshake: start is sampled only while the block is idle; busy rises the
// cycle after an accepted start and stays high until done pulses for exactly
// one cycle. matrix_a/matrix_b (and trans_b) must stay stable while busy=1.
// matrix_c is valid as a set while done=1 and holds until the next operation.
interface matrix_mult_if #(
  parameter int M = 4,
  parameter int K = 4,
  parameter int N = 4
);
  logic                                                 start;
  logic                                                 done;
  logic                                                 busy;
  logic                                                 ovf;
  logic [M-1:0][K-1:0][fp_arith_pkg::DATA_WIDTH-1:0]    matrix_a;
  logic [K-1:0][N-1:0][fp_arith_pkg::DATA_WIDTH-1:0]    matrix_b;
  logic [M-1:0][N-1:0][fp_arith_pkg::DATA_WIDTH-1:0]    matrix_c;
  logic [1:0]                                           dbg_state;
`ifdef MATRIX_MULT_TRANSPOSE_B_EN
  logic                                                 trans_b;

  modport master (output start, matrix_a, matrix_b, trans_b,
                  input  done, busy, ovf, matrix_c, dbg_state);
  modport slave  (input  start, matrix_a, matrix_b, trans_b,
                  output done, busy, ovf, matrix_c, dbg_state);
`else
  modport master (output start, matrix_a, matrix_b,
                  input  done, busy, ovf, matrix_c, dbg_state);
  modport slave  (input  start, matrix_a, matrix_b,
                  output done, busy, ovf, matrix_c, dbg_state);
`endif
endinterface

// File: rtl/matrix_mult_mac.sv
// mac_unit: signed DW x DW multiplier feeding a wide accumulator.
// i_clear has priority over i_en; the full product is sign-extended.
module mac_unit #(
  parameter int DW = 32,
  parameter int AW = 2 * DW + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_en,
  input  logic signed [DW-1:0] i_a,
  input  logic signed [DW-1:0] i_b,
  output logic signed [AW-1:0] o_acc
);
  logic signed [2*DW-1:0] w_prod;
  logic signed [AW-1:0]   r_acc;

  assign w_prod = i_a * i_b;
  assign o_acc  = r_acc;

  // Accumulate one product per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst || i_clear) r_acc <= '0;
    else if (i_en)      r_acc <= r_acc + AW'(w_prod);
  end
endmodule

// File: rtl/matrix_mult.sv
// matrix_mult: sequential Q16.16 C = A x B, one MAC per cycle, row-major.
// Optional macro MATRIX_MULT_TRANSPOSE_B_EN adds trans_b for C = A x B^T.
module matrix_mult
  import fp_arith_pkg::*;
#(
  parameter int M = 4,
  parameter int K = 4,
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          rst,
  matrix_mult_if.slave  bus
);
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = 2 * DATA_WIDTH + $clog2(K) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAC = 2'd1, S_WRITE = 2'd2, S_DONE = 2'd3} state_t;

  state_t                                r_state, w_next_state;
  logic [RW-1:0]                         r_row;
  logic [CW-1:0]                         r_col;
  logic [KW-1:0]                         r_k;
  logic                                  r_done, r_busy, r_ovf, r_trans;
  logic [M-1:0][N-1:0][DATA_WIDTH-1:0]   r_c;
  logic signed [DATA_WIDTH-1:0]          w_a, w_b;
  logic signed [AW-1:0]                  w_acc;
  logic                                  w_last_k, w_last_elem;
  fp_rs_t                                w_rs;

`ifdef MATRIX_MULT_TRANSPOSE_B_EN
  if (K != N) begin : g_trans_check
    $error("matrix_mult: transpose mode requires K == N");
  end
  assign w_b = r_trans ? bus.matrix_b[r_col][r_k] : bus.matrix_b[r_k][r_col];
`else
  assign w_b = bus.matrix_b[r_k][r_col];
`endif

  assign w_a         = bus.matrix_a[r_row][r_k];
  assign w_last_k    = (r_k == KW'(K - 1));
  assign w_last_elem = (r_row == RW'(M - 1)) && (r_col == CW'(N - 1));
  assign w_rs        = fp_round_sat(ACC_MAX_W'(w_acc));

  mac_unit #(.DW(DATA_WIDTH), .AW(AW)) u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state == S_IDLE || r_state == S_WRITE),
    .i_en    (r_state == S_MAC),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_acc   (w_acc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next_state = S_MAC;
      S_MAC:   if (w_last_k)  w_next_state = S_WRITE;
      S_WRITE: w_next_state = w_last_elem ? S_DONE : S_MAC;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Counters, result registers and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row   <= '0;
      r_col   <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
      r_trans <= 1'b0;
      r_c     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_row  <= '0;
            r_col  <= '0;
            r_k    <= '0;
            r_ovf  <= 1'b0;
            r_busy <= 1'b1;
`ifdef MATRIX_MULT_TRANSPOSE_B_EN
            r_trans <= bus.trans_b;
`else
            r_trans <= 1'b0;
`endif
          end
        end
        S_MAC: r_k <= w_last_k ? '0 : r_k + 1'b1;
        S_WRITE: begin
          r_c[r_row][r_col] <= w_rs.value;
          if (w_rs.ovf) r_ovf <= 1'b1;
          if (r_col == CW'(N - 1)) begin
            r_col <= '0;
            if (!w_last_elem) r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.done      = r_done;
  assign bus.busy      = r_busy;
  assign bus.ovf       = r_ovf;
  assign bus.matrix_c  = r_c;
  assign bus.dbg_state = r_state;
endmodule
